alu_exec_unit: RTL and testbench

//   Execute-stage ALU directly downstream of the ALU controller: consumes the 4-bit
//   ALU control code plus two operands and produces a registered result and zero flag.

---
 rtl/alu_exec_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT and an iterative shift-add MUL.
// Optional build macro ALU_OVF_EN adds the registered signed/unsigned overflow flag ovf_o.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
`ifdef ALU_OVF_EN
  output logic             valid_o,
  output logic             ovf_o
`else
  output logic             valid_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
`ifdef ALU_OVF_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic [ACC_W-1:0]   mcand_r, mcand_nxt_s;
  logic [WIDTH-1:0]   mplier_r, mplier_nxt_s;
  logic [WIDTH-1:0]   result_r, result_nxt_s;
  logic               zero_r, zero_nxt_s;
  logic               valid_r, valid_nxt_s;

  logic [WIDTH-1:0]   sum_s, diff_s, alu_s;
  logic [ACC_W-1:0]   acc_sum_s;
`ifdef ALU_OVF_EN
  logic               ovf_r, ovf_nxt_s;
  logic               alu_ovf_s;
`endif

  assign sum_s     = src1_i + src2_i;
  assign diff_s    = src1_i - src2_i;
  // The multiplicand is only added when the current multiplier bit is set.
  assign acc_sum_s = acc_r + (mplier_r[0] ? mcand_r : {ACC_W{1'b0}});

  // Single-cycle result from the live operands.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (ctrl_i)
      CTRL_AND: alu_s = src1_i & src2_i;
      CTRL_OR:  alu_s = src1_i | src2_i;
      CTRL_ADD: alu_s = sum_s;
      CTRL_SUB: alu_s = diff_s;
      CTRL_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default:  alu_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_OVF_EN
  // Two's-complement overflow for the single-cycle add/subtract.
  always_comb begin
    alu_ovf_s = 1'b0;
    case (ctrl_i)
      CTRL_ADD: alu_ovf_s = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != src1_i[WIDTH-1]);
      CTRL_SUB: alu_ovf_s = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != src1_i[WIDTH-1]);
      default:  alu_ovf_s = 1'b0;
    endcase
  end
`endif

  // Next-state and datapath update for the IDLE/MUL controller.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    acc_nxt_s    = acc_r;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    result_nxt_s = result_r;
    zero_nxt_s   = zero_r;
    valid_nxt_s  = 1'b0;
`ifdef ALU_OVF_EN
    ovf_nxt_s    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          if (ctrl_i == CTRL_MUL) begin
            acc_nxt_s    = {ACC_W{1'b0}};
            mcand_nxt_s  = ACC_W'(src1_i);
            mplier_nxt_s = src2_i;
            cnt_nxt_s    = CNT_W'(WIDTH - 1);
            state_nxt_s  = MUL;
          end else begin
            result_nxt_s = alu_s;
            zero_nxt_s   = (alu_s == {WIDTH{1'b0}});
            valid_nxt_s  = 1'b1;
`ifdef ALU_OVF_EN
            ovf_nxt_s    = alu_ovf_s;
`endif
            state_nxt_s  = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        acc_nxt_s    = acc_sum_s;
        mcand_nxt_s  = mcand_r << 1;
        mplier_nxt_s = mplier_r >> 1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          result_nxt_s = acc_sum_s[WIDTH-1:0];
          zero_nxt_s   = (acc_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
          valid_nxt_s  = 1'b1;
`ifdef ALU_OVF_EN
          ovf_nxt_s    = |acc_sum_s[ACC_W-1:WIDTH];
`endif
          state_nxt_s  = IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_W'(1);
          state_nxt_s = MUL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      mcand_r  <= {ACC_W{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b1;
      valid_r  <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      cnt_r    <= cnt_nxt_s;
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      result_r <= result_nxt_s;
      zero_r   <= zero_nxt_s;
      valid_r  <= valid_nxt_s;
`ifdef ALU_OVF_EN
      ovf_r    <= ovf_nxt_s;
`endif
    end
  end

  assign ready_o  = (state_r == IDLE);
  assign result_o = result_r;
  assign zero_o   = zero_r;
  assign valid_o  = valid_r;
`ifdef ALU_OVF_EN
  assign ovf_o    = ovf_r;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32): directed cases plus randomized ops
// checked against an arithmetic reference model; ovf_o checks follow ALU_OVF_EN.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [3:0]   ctrl_i = 4'b0000;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         valid_o;
`ifdef ALU_OVF_EN
  logic         ovf_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .result_o (result_o),
    .zero_o   (zero_o),
`ifdef ALU_OVF_EN
    .valid_o  (valid_o),
    .ovf_o    (ovf_o)
`else
    .valid_o  (valid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain arithmetic on the operation's meaning.
  function automatic logic [W-1:0] ref_result(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin p = longint'(a) * longint'(b); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    longint lim_hi;
    longint unsigned p;
    lim_hi = 2147483647;
    case (c)
      4'b0010: begin s = longint'($signed(a)) + longint'($signed(b)); return (s > lim_hi) || (s < -lim_hi - 1); end
      4'b0110: begin s = longint'($signed(a)) - longint'($signed(b)); return (s > lim_hi) || (s < -lim_hi - 1); end
      4'b1000: begin p = longint'(a) * longint'(b); return (p >> 32) != 0; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i = v;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
  endtask

  // Passes the accepting edge, drops valid_i, then counts cycles until valid_o (bounded).
  task automatic wait_done(output int lat);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 64) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_tests++; if (result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
    n_tests++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero_o); end
`ifdef ALU_OVF_EN
    n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
`endif
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    @(posedge clk_i); #1;
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_add_valid got %b want 1", valid_o); end
    n_tests++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_add_result got %h want 80000000", result_o); end
    n_tests++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL b2b_add_zero got %b want 0", zero_o); end
`ifdef ALU_OVF_EN
    n_tests++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL b2b_add_ovf got %b want 1", ovf_o); end
`endif
    drive(1'b1, 4'b0110, 32'd5, 32'd5);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_valid got %b want 1", valid_o); end
    n_tests++; if (result_o !== 32'd0) begin n_fail++; $display("FAIL b2b_sub_result got %h want 0", result_o); end
    n_tests++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_zero got %b want 1", zero_o); end
`ifdef ALU_OVF_EN
    n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL b2b_sub_ovf got %b want 0", ovf_o); end
`endif
    @(posedge clk_i); #1;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %b want 0", valid_o); end
  endtask

  task automatic test_slt_and;
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk_i); #1;
    drive(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_tests++; if (result_o !== 32'd1 || valid_o !== 1'b1) begin n_fail++; $display("FAIL slt_neg got %h/%b want 1/1", result_o, valid_o); end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_tests++; if (result_o !== 32'hF000_F000 || valid_o !== 1'b1) begin n_fail++; $display("FAIL and_mask got %h/%b want f000f000/1", result_o, valid_o); end
  endtask

  task automatic test_mul;
    int lat;
    int busy;
    drive(1'b1, 4'b1000, 32'd1234, 32'd5678);
    @(posedge clk_i); #1;
    lat = 0;
    busy = 0;
    while (!valid_o && lat < 64) begin
      if (!ready_o) busy++;
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      @(posedge clk_i); #1;
      lat++;
    end
    valid_i = 1'b0;
    n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL mul_latency got %0d want 32", lat); end
    n_tests++; if (busy !== 32) begin n_fail++; $display("FAIL mul_busy got %0d want 32", busy); end
    n_tests++; if (result_o !== 32'd7006652) begin n_fail++; $display("FAIL mul_result got %0d want 7006652", result_o); end
    @(posedge clk_i); #1;
    n_tests++; if (valid_o !== 1'b0 || result_o !== 32'd7006652) begin n_fail++; $display("FAIL mul_hold got %b/%0d want 0/7006652", valid_o, result_o); end
  endtask

  task automatic test_mul_overflow;
    int lat;
    drive(1'b1, 4'b1000, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat);
    n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL mulovf_latency got %0d want 32", lat); end
    n_tests++; if (result_o !== 32'd0 || zero_o !== 1'b1) begin n_fail++; $display("FAIL mulovf_result got %h/%b want 0/1", result_o, zero_o); end
`ifdef ALU_OVF_EN
    n_tests++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL mulovf_ovf got %b want 1", ovf_o); end
`endif
  endtask

  task automatic test_undefined;
    drive(1'b1, 4'b0001, 32'h0000_00A5, 32'h0000_5A00);
    @(posedge clk_i); #1;
    drive(1'b1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL undef_valid got %b want 1", valid_o); end
    n_tests++; if (result_o !== 32'd0 || zero_o !== 1'b1) begin n_fail++; $display("FAIL undef_result got %h/%b want 0/1", result_o, zero_o); end
  endtask

  task automatic test_reset_mid_mul;
    int pulses;
    drive(1'b1, 4'b1000, 32'h0000_1234, 32'h0000_5678);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_tests++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmul_ctrl got ready=%b valid=%b want 1/0", ready_o, valid_o); end
    n_tests++; if (result_o !== 32'd0 || zero_o !== 1'b1) begin n_fail++; $display("FAIL rstmul_result got %h/%b want 0/1", result_o, zero_o); end
    pulses = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmul_no_pulse got %0d want 0", pulses); end
  endtask

  task automatic test_random;
    logic [3:0] codes [7];
    logic [3:0] c;
    logic [W-1:0] a, b, exp_r;
    int lat, exp_lat;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0011};
    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 6)];
      if (c == 4'b0011) c = 4'($urandom_range(9, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (c == 4'b1000 && $urandom_range(0, 1) == 1) begin
        a = a >> 16;
        b = b >> 20;
      end
      exp_r = ref_result(c, a, b);
      exp_lat = (c == 4'b1000) ? 32 : 0;
      drive(1'b1, c, a, b);
      wait_done(lat);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency op=%b got %0d want %0d", c, lat, exp_lat); end
      n_tests++; if (result_o !== exp_r) begin n_fail++; $display("FAIL rand_result op=%b a=%h b=%h got %h want %h", c, a, b, result_o, exp_r); end
      n_tests++; if (zero_o !== (exp_r == 32'd0)) begin n_fail++; $display("FAIL rand_zero op=%b got %b want %b", c, zero_o, (exp_r == 32'd0)); end
`ifdef ALU_OVF_EN
      n_tests++; if (ovf_o !== ref_ovf(c, a, b)) begin n_fail++; $display("FAIL rand_ovf op=%b a=%h b=%h got %b want %b", c, a, b, ovf_o, ref_ovf(c, a, b)); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_slt_and;
    test_mul;
    test_mul_overflow;
    test_undefined;
    test_reset_mid_mul;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
